// File: rtl/maze_dfs_engine.sv
// Depth-first maze solver controller: walks a 2^COORD_W square grid, marking cells in an
// external visited RAM and keeping {dir,loc} backtrack frames in an external LIFO.
module maze_dfs_engine #(
   parameter int                   COORD_W   = 4,
   parameter logic [2*COORD_W-1:0] START_LOC = '0,
   parameter logic [2*COORD_W-1:0] DEST_LOC  = '1,
   parameter int                   MAX_STEPS = 1024,
   parameter int                   STEP_W    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 mem_rdata,
   input  logic [2*COORD_W+1:0] stk_dout,
   input  logic                 stk_empty,
   input  logic                 stk_full,
   output logic [2*COORD_W-1:0] mem_addr,
   output logic                 mem_rd,
   output logic                 mem_wr,
   output logic [2*COORD_W+1:0] stk_din,
   output logic                 push,
   output logic                 pop,
   output logic                 stk_clr,
   output logic [2*COORD_W-1:0] curr_loc,
   output logic                 busy,
   output logic                 done,
   output logic                 fail,
   output logic [1:0]           fail_code,
   output logic [STEP_W-1:0]    step_count
);

   localparam int                 LOC_W     = 2 * COORD_W;
   localparam logic [COORD_W-1:0] C_ONE     = 1;
   localparam logic [COORD_W-1:0] C_MAX     = '1;
   localparam logic [STEP_W-1:0]  STEP_ONE  = 1;
   localparam logic [STEP_W-1:0]  STEP_LIM  = STEP_W'(MAX_STEPS);
   localparam bit                 BUDGET_ON = (MAX_STEPS != 0);

   localparam logic [1:0] CODE_NONE     = 2'b00;
   localparam logic [1:0] CODE_NO_PATH  = 2'b01;
   localparam logic [1:0] CODE_OVERFLOW = 2'b10;
   localparam logic [1:0] CODE_BUDGET   = 2'b11;

   typedef enum logic [3:0] {
      S_IDLE,
      S_INIT,
      S_CHECK,
      S_PROBE,
      S_WAIT,
      S_ADV,
      S_BACK,
      S_RESTORE,
      S_DONE,
      S_FAIL
   } state_t;

   state_t             state, state_n;
   logic [2:0]         dir, dir_n;
   logic [LOC_W-1:0]   loc_n;
   logic [STEP_W-1:0]  step_n, step_inc;
   logic [1:0]         code_n;
   logic               budget_hit;

   logic [COORD_W-1:0] cx, cy, nx, ny;
   logic [LOC_W-1:0]   nbr;
   logic               nbr_oob;

   // Neighbour in the current direction; any coordinate under/overflow is out of bounds.
   always_comb begin
      cx      = curr_loc[COORD_W-1:0];
      cy      = curr_loc[LOC_W-1:COORD_W];
      nx      = cx;
      ny      = cy;
      nbr_oob = 1'b0;
      case (dir[1:0])
         2'd0: begin
            nbr_oob = (cy == '0);
            ny      = cy - C_ONE;
         end
         2'd1: begin
            nbr_oob = (cx == C_MAX);
            nx      = cx + C_ONE;
         end
         2'd2: begin
            nbr_oob = (cy == C_MAX);
            ny      = cy + C_ONE;
         end
         default: begin
            nbr_oob = (cx == '0);
            nx      = cx - C_ONE;
         end
      endcase
      nbr = {ny, nx};
   end

   // Memory and stack strobes are single-cycle requests with no back-pressure: the RAM
   // returns mem_rdata and the stack returns stk_dout on the cycle after mem_rd/pop.
   always_comb begin
      state_n    = state;
      loc_n      = curr_loc;
      dir_n      = dir;
      step_n     = step_count;
      code_n     = fail_code;
      mem_addr   = curr_loc;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;
      stk_clr    = 1'b0;
      stk_din    = {dir[1:0], curr_loc};
      step_inc   = step_count + STEP_ONE;
      budget_hit = BUDGET_ON && (step_inc == STEP_LIM);

      case (state)
         S_IDLE, S_DONE, S_FAIL: begin
            if (start) begin
               state_n = S_INIT;
               loc_n   = START_LOC;
               dir_n   = '0;
               step_n  = '0;
               code_n  = CODE_NONE;
            end
         end
         S_INIT: begin
            mem_wr  = 1'b1;
            stk_clr = 1'b1;
            state_n = S_CHECK;
         end
         S_CHECK: begin
            state_n = (curr_loc == DEST_LOC) ? S_DONE : S_PROBE;
         end
         S_PROBE: begin
            if (dir[2]) begin
               state_n = S_BACK;
            end else if (nbr_oob) begin
               dir_n = dir + 3'd1;
            end else begin
               mem_rd   = 1'b1;
               mem_addr = nbr;
               state_n  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (mem_rdata) begin
               dir_n   = dir + 3'd1;
               state_n = S_PROBE;
            end else if (stk_full) begin
               code_n  = CODE_OVERFLOW;
               state_n = S_FAIL;
            end else begin
               state_n = S_ADV;
            end
         end
         S_ADV: begin
            push     = 1'b1;
            mem_wr   = 1'b1;
            mem_addr = nbr;
            loc_n    = nbr;
            dir_n    = '0;
            step_n   = step_inc;
            // Budget exhaustion only loses to actually landing on the destination.
            if (budget_hit) begin
               if (nbr == DEST_LOC) begin
                  state_n = S_DONE;
               end else begin
                  code_n  = CODE_BUDGET;
                  state_n = S_FAIL;
               end
            end else begin
               state_n = S_CHECK;
            end
         end
         S_BACK: begin
            if (stk_empty) begin
               code_n  = CODE_NO_PATH;
               state_n = S_FAIL;
            end else begin
               pop     = 1'b1;
               state_n = S_RESTORE;
            end
         end
         S_RESTORE: begin
            loc_n  = stk_dout[LOC_W-1:0];
            dir_n  = {1'b0, stk_dout[LOC_W+1:LOC_W]} + 3'd1;
            step_n = step_inc;
            if (budget_hit) begin
               code_n  = CODE_BUDGET;
               state_n = S_FAIL;
            end else begin
               state_n = S_PROBE;
            end
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase

      if (abort) begin
         state_n = S_IDLE;
         loc_n   = curr_loc;
         dir_n   = dir;
         step_n  = step_count;
         code_n  = CODE_NONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         curr_loc   <= START_LOC;
         dir        <= '0;
         step_count <= '0;
         fail_code  <= CODE_NONE;
      end else begin
         state      <= state_n;
         curr_loc   <= loc_n;
         dir        <= dir_n;
         step_count <= step_n;
         fail_code  <= code_n;
      end
   end

   assign busy = !((state == S_IDLE) || (state == S_DONE) || (state == S_FAIL));
   assign done = (state == S_DONE);
   assign fail = (state == S_FAIL);

endmodule

// File: tb/tb_maze_dfs_engine.sv
// Bench for maze_dfs_engine on a 4x4 grid: two instances (large and tiny step budget), each
// with a behavioural visited RAM and stack, checked against a queue-based DFS reference.
module tb_maze_dfs_engine;

   localparam int CW    = 2;
   localparam int LW    = 4;
   localparam int FW    = 6;
   localparam int SW    = 16;
   localparam int NC    = 16;
   localparam int DEPTH = 16;
   localparam int DEST  = 15;
   localparam int TMO   = 4000;

   logic clk = 1'b0;
   logic rst;

   logic          start_v[2];
   logic          abort_v[2];
   logic          force_full_v[2];
   logic          clr_v[2];
   logic          wall[2][NC];
   logic [LW-1:0] mem_addr_v[2];
   logic [LW-1:0] curr_loc_v[2];
   logic          mem_rd_v[2];
   logic          mem_wr_v[2];
   logic          push_v[2];
   logic          pop_v[2];
   logic          stk_clr_v[2];
   logic          busy_v[2];
   logic          done_v[2];
   logic          fail_v[2];
   logic [FW-1:0] stk_din_v[2];
   logic [1:0]    fail_code_v[2];
   logic [SW-1:0] step_count_v[2];
   int            push_cnt_v[2];

   int total = 0;
   int bad   = 0;
   int act_visits = 0;

   logic [LW-1:0] exp_q[$];
   logic [FW-1:0] frm_q[$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : env
      logic          visited[NC];
      logic [FW-1:0] stk[DEPTH];
      int            sp = 0;
      int            push_cnt = 0;
      logic          mem_rdata = 1'b0;
      logic [FW-1:0] stk_dout = '0;
      logic          stk_empty, stk_full;

      assign stk_empty     = (sp == 0);
      assign stk_full      = (sp == DEPTH) || force_full_v[g];
      assign push_cnt_v[g] = push_cnt;

      always @(posedge clk) begin
         if (clr_v[g]) begin
            for (int k = 0; k < NC; k++) visited[k] <= 1'b0;
            push_cnt <= 0;
         end else begin
            if (mem_wr_v[g]) visited[mem_addr_v[g]] <= 1'b1;
            if (push_v[g]) push_cnt <= push_cnt + 1;
         end
         if (mem_rd_v[g]) mem_rdata <= wall[g][mem_addr_v[g]] | visited[mem_addr_v[g]];
         if (stk_clr_v[g]) begin
            sp <= 0;
         end else if (push_v[g] && sp < DEPTH) begin
            stk[sp] <= stk_din_v[g];
            sp      <= sp + 1;
         end else if (pop_v[g] && sp > 0) begin
            stk_dout <= stk[sp-1];
            sp       <= sp - 1;
         end
      end

      maze_dfs_engine #(
         .COORD_W  (CW),
         .MAX_STEPS((g == 0) ? 1024 : 3),
         .STEP_W   (SW)
      ) dut (
         .clk       (clk),
         .rst       (rst),
         .start     (start_v[g]),
         .abort     (abort_v[g]),
         .mem_rdata (mem_rdata),
         .stk_dout  (stk_dout),
         .stk_empty (stk_empty),
         .stk_full  (stk_full),
         .mem_addr  (mem_addr_v[g]),
         .mem_rd    (mem_rd_v[g]),
         .mem_wr    (mem_wr_v[g]),
         .stk_din   (stk_din_v[g]),
         .push      (push_v[g]),
         .pop       (pop_v[g]),
         .stk_clr   (stk_clr_v[g]),
         .curr_loc  (curr_loc_v[g]),
         .busy      (busy_v[g]),
         .done      (done_v[g]),
         .fail      (fail_v[g]),
         .fail_code (fail_code_v[g]),
         .step_count(step_count_v[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Strobe exclusivity, visit order, push frames and no-revisit for instance 0.
   always @(negedge clk) begin
      if ($countones({mem_rd_v[0], mem_wr_v[0], push_v[0], pop_v[0]}) > 1)
         chk("strobe_combo", {28'd0, mem_rd_v[0], mem_wr_v[0], push_v[0], pop_v[0]}, 32'h6);
      if (mem_wr_v[0] && !stk_clr_v[0]) begin
         act_visits++;
         chk("visit_fresh", {31'd0, env[0].visited[mem_addr_v[0]]}, 32'd0);
         if (exp_q.size() > 0) chk("visit_order", {28'd0, mem_addr_v[0]}, {28'd0, exp_q.pop_front()});
      end
      if (push_v[0] && frm_q.size() > 0)
         chk("push_frame", {26'd0, stk_din_v[0]}, {26'd0, frm_q.pop_front()});
   end

   // Reference DFS: explicit frame lists, directions tried in order up/right/down/left.
   task automatic model(input int i, input int bud, input bit ff,
                        output int code, output int fin, output int steps, output int pushes);
      bit vis[NC];
      int fl[$];
      int fd[$];
      int loc, d, n, y, x;
      bit ok, found;
      for (int k = 0; k < NC; k++) vis[k] = 1'b0;
      loc = 0; d = 0; n = 0; vis[0] = 1'b1; steps = 0; pushes = 0; code = -1;
      if (loc == DEST) code = 0;
      while (code < 0) begin
         found = 1'b0;
         while (d < 4 && !found) begin
            y = loc / 4; x = loc % 4;
            case (d)
               0: begin ok = (y > 0); n = loc - 4; end
               1: begin ok = (x < 3); n = loc + 1; end
               2: begin ok = (y < 3); n = loc + 4; end
               default: begin ok = (x > 0); n = loc - 1; end
            endcase
            if (ok && !wall[i][n] && !vis[n]) found = 1'b1;
            else d++;
         end
         if (found) begin
            if (ff || fl.size() == DEPTH) begin
               code = 2;
            end else begin
               fl.push_back(loc); fd.push_back(d); pushes++;
               if (i == 0) begin
                  exp_q.push_back(LW'(n));
                  frm_q.push_back(FW'((d << 4) | loc));
               end
               vis[n] = 1'b1; loc = n; d = 0; steps++;
               if (loc == DEST) code = 0;
               else if (bud != 0 && steps == bud) code = 3;
            end
         end else if (fl.size() == 0) begin
            code = 1;
         end else begin
            loc = fl.pop_back(); d = fd.pop_back() + 1; steps++;
            if (bud != 0 && steps == bud) code = 3;
         end
      end
      fin = loc;
   endtask

   task automatic clear_env(input int i);
      @(posedge clk); #1 clr_v[i] = 1'b1;
      @(posedge clk); #1 clr_v[i] = 1'b0;
   endtask

   task automatic pulse_start(input int i);
      @(posedge clk); #1 start_v[i] = 1'b1;
      @(posedge clk); #1 start_v[i] = 1'b0;
   endtask

   task automatic run(input int i, input int bud, input bit ff, input string tag);
      int code, fin, steps, pushes, cyc;
      exp_q.delete(); frm_q.delete();
      model(i, bud, ff, code, fin, steps, pushes);
      force_full_v[i] = ff;
      clear_env(i);
      act_visits = 0;
      pulse_start(i);
      cyc = 0;
      while (!(done_v[i] || fail_v[i]) && cyc < TMO) begin
         @(negedge clk); cyc++;
      end
      chk({tag, "_timeout"}, {31'd0, cyc < TMO}, 32'd1);
      chk({tag, "_done"}, {31'd0, done_v[i]}, {31'd0, code == 0});
      chk({tag, "_fail"}, {31'd0, fail_v[i]}, {31'd0, code != 0});
      chk({tag, "_code"}, {30'd0, fail_code_v[i]}, 32'(code));
      chk({tag, "_loc"}, {28'd0, curr_loc_v[i]}, 32'(fin));
      chk({tag, "_steps"}, {16'd0, step_count_v[i]}, 32'(steps));
      chk({tag, "_busy"}, {31'd0, busy_v[i]}, 32'd0);
      @(negedge clk);
      chk({tag, "_pushes"}, 32'(push_cnt_v[i]), 32'(pushes));
      if (i == 0) begin
         chk({tag, "_visits"}, 32'(act_visits), 32'(pushes));
         chk({tag, "_left"}, 32'(exp_q.size() + frm_q.size()), 32'd0);
      end
      force_full_v[i] = 1'b0;
   endtask

   task automatic open_maze(input int i);
      for (int c = 0; c < NC; c++) wall[i][c] = 1'b0;
   endtask

   initial begin
      int cyc;
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         start_v[i] = 1'b0; abort_v[i] = 1'b0; force_full_v[i] = 1'b0; clr_v[i] = 1'b0;
         open_maze(i);
      end
      repeat (3) @(negedge clk);

      // Reset state of both instances.
      for (int i = 0; i < 2; i++) begin
         chk("rst_busy", {31'd0, busy_v[i]}, 32'd0);
         chk("rst_flags", {29'd0, done_v[i], fail_code_v[i]}, 32'd0);
         chk("rst_fail", {31'd0, fail_v[i]}, 32'd0);
         chk("rst_loc", {28'd0, curr_loc_v[i]}, 32'd0);
         chk("rst_steps", {16'd0, step_count_v[i]}, 32'd0);
         chk("rst_strobes", {27'd0, mem_rd_v[i], mem_wr_v[i], push_v[i], pop_v[i], stk_clr_v[i]}, 32'd0);
      end
      @(posedge clk); #1 rst = 1'b0;

      // Open maze reaches 15 via 1,2,3,7,11,15.
      run(0, 1024, 1'b0, "open");
      chk("open_steps6", {16'd0, step_count_v[0]}, 32'd6);

      // Destination sealed off: full exploration, then empty stack.
      wall[0][11] = 1'b1; wall[0][14] = 1'b1;
      run(0, 1024, 1'b0, "nopath");
      chk("nopath_code01", {30'd0, fail_code_v[0]}, 32'd1);

      // Stack full before the first advance.
      open_maze(0);
      run(0, 1024, 1'b1, "full");
      chk("full_code10", {30'd0, fail_code_v[0]}, 32'd2);

      // Step budget of 3 stops at cell 3.
      open_maze(1);
      run(1, 3, 1'b0, "budget");
      chk("budget_loc3", {28'd0, curr_loc_v[1]}, 32'd3);

      // Dead end at 1 forces a pop back to 0, resuming downward.
      open_maze(0);
      wall[0][2] = 1'b1; wall[0][5] = 1'b1;
      run(0, 1024, 1'b0, "deadend");

      // Abort mid-run.
      open_maze(0);
      exp_q.delete(); frm_q.delete();
      clear_env(0);
      pulse_start(0);
      repeat (4) @(posedge clk);
      #1 abort_v[0] = 1'b1;
      @(posedge clk); #1 abort_v[0] = 1'b0;
      @(negedge clk);
      chk("abort_busy", {31'd0, busy_v[0]}, 32'd0);
      chk("abort_flags", {28'd0, done_v[0], fail_v[0], fail_code_v[0]}, 32'd0);
      run(0, 1024, 1'b0, "after_abort");

      // Reset while waiting on a RAM read.
      exp_q.delete(); frm_q.delete();
      clear_env(0);
      pulse_start(0);
      cyc = 0;
      while (!mem_rd_v[0] && cyc < 50) begin
         @(negedge clk); cyc++;
      end
      chk("rst_wait_reach", {31'd0, cyc < 50}, 32'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", {31'd0, busy_v[0]}, 32'd0);
      chk("midrst_strobes", {27'd0, mem_rd_v[0], mem_wr_v[0], push_v[0], pop_v[0], stk_clr_v[0]}, 32'd0);
      chk("midrst_loc", {28'd0, curr_loc_v[0]}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      run(0, 1024, 1'b0, "rerun");
      chk("rerun_steps6", {16'd0, step_count_v[0]}, 32'd6);

      // Random mazes, unlimited-ish budget.
      for (int t = 0; t < 10; t++) begin
         for (int c = 0; c < NC; c++) wall[0][c] = ($urandom_range(0, 99) < 30);
         wall[0][0] = 1'b0;
         run(0, 1024, 1'b0, "rand");
      end

      // Random mazes, tiny budget.
      for (int t = 0; t < 4; t++) begin
         for (int c = 0; c < NC; c++) wall[1][c] = ($urandom_range(0, 99) < 35);
         wall[1][0] = 1'b0;
         run(1, 3, 1'b0, "rand_bud");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
